// File: rtl/instruction_fetch.sv
// Single-outstanding instruction fetch unit: IDLE -> REQ -> WAIT -> HOLD handshake
// between the PC, instruction memory and decode. Optional macro: FETCH_MISALIGN_CHECK_EN.
module instruction_fetch #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_i,
  input  logic        pc_valid_i,
  output logic        pc_ready_o,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        flush_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  input  logic        inst_ready_i,
  output logic        fetch_done_o,
  output logic        fault_o
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        misalign_o
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_e;

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`ifdef FETCH_MISALIGN_CHECK_EN
  localparam logic [31:0] NOP = 32'h0000_0013;
`endif

  state_e           state_q;
  logic [31:0]      addr_q;
  logic [31:0]      inst_q;
  logic [31:0]      inst_pc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             drop_q;   // one response still owed by memory must be discarded
  logic             kill_q;   // current request was flushed while waiting for gnt
  logic             fault_q;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic             misalign_q;
`endif

  // NOTE: every register here, including the data latches, is reset asynchronously
  // so that a reset mid-fetch leaves no stale instruction or pending drop behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      inst_q     <= '0;
      inst_pc_q  <= '0;
      cnt_q      <= '0;
      drop_q     <= 1'b0;
      kill_q     <= 1'b0;
      fault_q    <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments only; a later assignment in this block
      // deliberately overrides this default clear of the drop flag.
      if (imem_rvalid_i && (state_q != WAIT) && !(state_q == REQ && imem_gnt_i))
        drop_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (pc_valid_i && !flush_i) begin
            addr_q  <= pc_i;
            state_q <= REQ;
`ifdef FETCH_MISALIGN_CHECK_EN
            if (pc_i[1:0] != 2'b00) begin
              inst_q     <= NOP;
              inst_pc_q  <= pc_i;
              misalign_q <= 1'b1;
              state_q    <= HOLD;
            end
`endif
          end
        end

        REQ: begin
          if (flush_i) kill_q <= 1'b1;
          // The request is never withdrawn; a flushed request still waits for gnt.
          if (imem_gnt_i) begin
            kill_q <= 1'b0;
            cnt_q  <= '0;
            if (flush_i || kill_q) begin
              drop_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              state_q <= WAIT;
            end
          end
        end

        WAIT: begin
          if (flush_i) begin
            drop_q  <= drop_q | ~imem_rvalid_i;
            state_q <= IDLE;
          end else if (imem_rvalid_i && !drop_q) begin
            inst_q    <= imem_rdata_i;
            inst_pc_q <= addr_q;
            state_q   <= HOLD;
          end else begin
            if (imem_rvalid_i) drop_q <= 1'b0;
            if (cnt_q == CNT_LAST) begin
              fault_q <= 1'b1;
              state_q <= IDLE;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end

        HOLD: begin
          if (flush_i || inst_ready_i) begin
            state_q <= IDLE;
`ifdef FETCH_MISALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign pc_ready_o   = (state_q == IDLE);
  assign imem_req_o   = (state_q == REQ);
  assign imem_addr_o  = addr_q;
  assign inst_valid_o = (state_q == HOLD);
  assign inst_o       = inst_q;
  assign inst_pc_o    = inst_pc_q;
  assign fetch_done_o = (state_q == HOLD) && inst_ready_i && !flush_i;
  assign fault_o      = fault_q;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign misalign_o   = misalign_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed cases plus randomized fetches
// scored against a memory-content function and an expected-instruction queue.
module tb_instruction_fetch;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_i;
  logic        pc_valid_i;
  logic        pc_ready_o;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        flush_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_ready_i;
  logic        fetch_done_o;
  logic        fault_o;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        misalign_o;
`endif

  instruction_fetch #(.TIMEOUT_CYCLES(TO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_i          (pc_i),
    .pc_valid_i    (pc_valid_i),
    .pc_ready_o    (pc_ready_o),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .flush_i       (flush_i),
    .inst_valid_o  (inst_valid_o),
    .inst_o        (inst_o),
    .inst_pc_o     (inst_pc_o),
    .inst_ready_i  (inst_ready_i),
    .fetch_done_o  (fetch_done_o),
    .fault_o       (fault_o)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .misalign_o    (misalign_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_t;

  fetch_t exp_q[$];
  int     errors = 0;
  int     checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven from here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
  endfunction

  task automatic quiet_inputs();
    pc_i          = '0;
    pc_valid_i    = 1'b0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    flush_i       = 1'b0;
    inst_ready_i  = 1'b0;
  endtask

  // One complete fetch: gd cycles before gnt, rvalid rd cycles after gnt,
  // decode stalls hd cycles. junk drives a bogus rvalid alongside gnt.
  task automatic fetch(input logic [31:0] pc, input int gd, input int rd, input int hd,
                       input logic [31:0] data, input logic junk);
    fetch_t f;
    check("idle_pc_ready", 32'(pc_ready_o), 32'd1);
    pc_i = pc;
    pc_valid_i = 1'b1;
    exp_q.push_back('{pc: pc, inst: data});
    tick();
    pc_valid_i = 1'b0;
    pc_i = $urandom;
    for (int g = 0; g <= gd; g++) begin
      imem_gnt_i    = (g == gd);
      imem_rvalid_i = junk && (g == gd);
      imem_rdata_i  = 32'hBAD0_0000 | 32'(g);
      check("req_active", 32'(imem_req_o), 32'd1);
      check("req_addr", imem_addr_o, pc);
      check("req_pc_ready", 32'(pc_ready_o), 32'd0);
      tick();
    end
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    for (int w = 1; w <= rd; w++) begin
      imem_rvalid_i = (w == rd);
      imem_rdata_i  = (w == rd) ? data : $urandom;
      check("wait_no_valid", 32'(inst_valid_o), 32'd0);
      check("wait_no_req", 32'(imem_req_o), 32'd0);
      tick();
    end
    imem_rvalid_i = 1'b0;
    f = exp_q.pop_front();
    for (int h = 0; h <= hd; h++) begin
      inst_ready_i = (h == hd);
      #1;
      check("hold_valid", 32'(inst_valid_o), 32'd1);
      check("hold_inst", inst_o, f.inst);
      check("hold_pc", inst_pc_o, f.pc);
      check("hold_pc_ready", 32'(pc_ready_o), 32'd0);
      check("hold_done", 32'(fetch_done_o), 32'(h == hd));
      tick();
    end
    inst_ready_i = 1'b0;
    #1;
    check("after_valid", 32'(inst_valid_o), 32'd0);
    check("after_done", 32'(fetch_done_o), 32'd0);
    check("after_pc_ready", 32'(pc_ready_o), 32'd1);
  endtask

  task automatic check_reset_values();
    check("rst_pc_ready", 32'(pc_ready_o), 32'd1);
    check("rst_req", 32'(imem_req_o), 32'd0);
    check("rst_addr", imem_addr_o, 32'd0);
    check("rst_valid", 32'(inst_valid_o), 32'd0);
    check("rst_inst", inst_o, 32'd0);
    check("rst_inst_pc", inst_pc_o, 32'd0);
    check("rst_done", 32'(fetch_done_o), 32'd0);
    check("rst_fault", 32'(fault_o), 32'd0);
  endtask

  initial begin
    logic [31:0] pc;

    // Reset state
    quiet_inputs();
    rst_n = 1'b0;
    #2;
    check_reset_values();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_reset_values();

    // Zero-wait memory: inst_valid three cycles after pc accept
    fetch(32'h0000_0100, 0, 1, 0, 32'h0050_0093, 1'b0);
    // Delayed grant, delayed response
    fetch(32'h0000_0104, 3, 2, 0, mem_word(32'h104), 1'b0);

    // Randomized fetches against the memory model
    for (int i = 0; i < 20; i++) begin
      pc = $urandom & 32'hFFFF_FFFC;
      fetch(pc, $urandom_range(0, 3), $urandom_range(1, 3), $urandom_range(0, 3),
            mem_word(pc), 1'($urandom_range(0, 1)));
    end

    // Flush in IDLE: pc_valid ignored
    pc_i = 32'h0000_0700;
    pc_valid_i = 1'b1;
    flush_i = 1'b1;
    tick();
    pc_valid_i = 1'b0;
    flush_i = 1'b0;
    check("idle_flush_stay", 32'(pc_ready_o), 32'd1);
    check("idle_flush_no_req", 32'(imem_req_o), 32'd0);

    // Flush in WAIT, late response discarded
    pc_i = 32'h0000_0200;
    pc_valid_i = 1'b1;
    tick();
    pc_valid_i = 1'b0;
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i = 32'hDEAD_BEEF;
    #1;
    check("wflush_valid", 32'(inst_valid_o), 32'd0);
    check("wflush_done", 32'(fetch_done_o), 32'd0);
    tick();
    imem_rvalid_i = 1'b0;
    check("wflush_valid2", 32'(inst_valid_o), 32'd0);
    check("wflush_idle", 32'(pc_ready_o), 32'd1);
    fetch(32'h0000_0204, 0, 1, 0, mem_word(32'h204), 1'b0);

    // Flush in REQ: request held until gnt, response discarded
    pc_i = 32'h0000_0300;
    pc_valid_i = 1'b1;
    tick();
    pc_valid_i = 1'b0;
    flush_i = 1'b1;
    check("rflush_req", 32'(imem_req_o), 32'd1);
    tick();
    flush_i = 1'b0;
    imem_gnt_i = 1'b1;
    check("rflush_req_held", 32'(imem_req_o), 32'd1);
    check("rflush_addr_held", imem_addr_o, 32'h0000_0300);
    tick();
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i = 32'hDEAD_BEEF;
    check("rflush_valid", 32'(inst_valid_o), 32'd0);
    tick();
    imem_rvalid_i = 1'b0;
    check("rflush_valid2", 32'(inst_valid_o), 32'd0);
    check("rflush_idle", 32'(pc_ready_o), 32'd1);
    fetch(32'h0000_0304, 0, 1, 1, mem_word(32'h304), 1'b0);

    // Flush in HOLD with decode ready: no handoff
    pc_i = 32'h0000_0800;
    pc_valid_i = 1'b1;
    tick();
    pc_valid_i = 1'b0;
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i = 32'h1111_2222;
    tick();
    imem_rvalid_i = 1'b0;
    check("hflush_hold", 32'(inst_valid_o), 32'd1);
    flush_i = 1'b1;
    inst_ready_i = 1'b1;
    #1;
    check("hflush_no_done", 32'(fetch_done_o), 32'd0);
    tick();
    flush_i = 1'b0;
    inst_ready_i = 1'b0;
    check("hflush_valid", 32'(inst_valid_o), 32'd0);
    check("hflush_idle", 32'(pc_ready_o), 32'd1);

    // Timeout: no response for TO cycles in WAIT
    pc_i = 32'h0000_0400;
    pc_valid_i = 1'b1;
    tick();
    pc_valid_i = 1'b0;
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0;
    for (int w = 1; w <= TO; w++) begin
      check("to_no_fault", 32'(fault_o), 32'd0);
      check("to_waiting", 32'(pc_ready_o), 32'd0);
      tick();
    end
    check("to_fault", 32'(fault_o), 32'd1);
    check("to_idle", 32'(pc_ready_o), 32'd1);
    fetch(32'h0000_0408, 1, 2, 0, mem_word(32'h408), 1'b0);
    check("to_fault_sticky", 32'(fault_o), 32'd1);

    // HOLD stall for 5 cycles, then reset
    pc_i = 32'h0000_0500;
    pc_valid_i = 1'b1;
    tick();
    pc_valid_i = 1'b0;
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i = 32'hCAFE_F00D;
    tick();
    imem_rvalid_i = 1'b0;
    for (int h = 0; h < 5; h++) begin
      check("stall_inst", inst_o, 32'hCAFE_F00D);
      check("stall_pc", inst_pc_o, 32'h0000_0500);
      check("stall_pc_ready", 32'(pc_ready_o), 32'd0);
      check("stall_fault", 32'(fault_o), 32'd1);
      tick();
    end
    rst_n = 1'b0;
    #1;
    check_reset_values();
    tick();
    rst_n = 1'b1;
    tick();

    // Reset mid-fetch, late response after release ignored
    pc_i = 32'h0000_0600;
    pc_valid_i = 1'b1;
    tick();
    pc_valid_i = 1'b0;
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    imem_rvalid_i = 1'b1;
    imem_rdata_i = 32'hDEAD_BEEF;
    tick();
    imem_rvalid_i = 1'b0;
    check("late_rvalid_valid", 32'(inst_valid_o), 32'd0);
    check("late_rvalid_inst", inst_o, 32'd0);
    check("late_rvalid_idle", 32'(pc_ready_o), 32'd1);
    fetch(32'h0000_0604, 0, 1, 0, mem_word(32'h604), 1'b0);

`ifdef FETCH_MISALIGN_CHECK_EN
    // Misaligned PC: NOP handed off without a memory request
    pc_i = 32'h0000_0102;
    pc_valid_i = 1'b1;
    tick();
    pc_valid_i = 1'b0;
    inst_ready_i = 1'b1;
    #1;
    check("mis_no_req", 32'(imem_req_o), 32'd0);
    check("mis_valid", 32'(inst_valid_o), 32'd1);
    check("mis_inst", inst_o, 32'h0000_0013);
    check("mis_pc", inst_pc_o, 32'h0000_0102);
    check("mis_flag", 32'(misalign_o), 32'd1);
    check("mis_done", 32'(fetch_done_o), 32'd1);
    tick();
    inst_ready_i = 1'b0;
    check("mis_flag_clear", 32'(misalign_o), 32'd0);
    check("mis_idle", 32'(pc_ready_o), 32'd1);
`else
    // Misaligned PC fetched as given
    fetch(32'h0000_0102, 0, 1, 0, mem_word(32'h102), 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
